// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// video_pkg : 720p60 timing defaults, totals helpers, sync bundle type.
// Revision  : 1.0
// ============================================================================
package video_pkg;

  localparam int H_ACTIVE_720P     = 1280;
  localparam int H_FP_720P         = 110;
  localparam int H_SYNC_720P       = 40;
  localparam int H_BP_720P         = 220;
  localparam int V_ACTIVE_720P     = 720;
  localparam int V_FP_720P         = 5;
  localparam int V_SYNC_720P       = 5;
  localparam int V_BP_720P         = 20;
  localparam int PIXEL_LATENCY_DEF = 4;

  localparam int HCOUNT_W       = 11;
  localparam int VCOUNT_W       = 10;
  localparam int RGB_W          = 12;
  localparam int FRAME_W        = 6;
  localparam int FRAMES_PER_SEC = 60;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [3:0] hcol;
  } sync_bundle_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Eight 128-column bars: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'hFF0;
      3'd2:    return 12'h0FF;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_delay.sv
`default_nettype none
// ============================================================================
// pipe_delay : WIDTH x DEPTH shift register, async reset; wire when DEPTH==0.
// Revision   : 1.0
// ============================================================================
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_in ^ rst_in;
      assign data_out       = data_in;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = data_in;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
        end
      end

      assign data_out = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// video_timing_gen : 720p60 raster counters, frame tick, latency-aligned
//                    sync/blank/pixel. Option macro: VIDEO_TEST_PATTERN_EN.
// Revision         : 1.0
// ============================================================================
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE      = H_ACTIVE_720P,
  parameter int H_FP          = H_FP_720P,
  parameter int H_SYNC        = H_SYNC_720P,
  parameter int H_BP          = H_BP_720P,
  parameter int V_ACTIVE      = V_ACTIVE_720P,
  parameter int V_FP          = V_FP_720P,
  parameter int V_SYNC        = V_SYNC_720P,
  parameter int V_BP          = V_BP_720P,
  parameter int PIXEL_LATENCY = PIXEL_LATENCY_DEF
) (
  input  logic                clk_in,
  input  logic                rst_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                new_frame_out,
  output logic [FRAME_W-1:0]  frame_count_out,
  input  logic [RGB_W-1:0]    pixel_in,
  input  logic                test_pattern_in,
  output logic [RGB_W-1:0]    pixel_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                active_draw_out
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HCOUNT_W-1:0] H_LAST      = HCOUNT_W'(H_TOTAL - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST      = VCOUNT_W'(V_TOTAL - 1);
  localparam logic [HCOUNT_W-1:0] H_ACT       = HCOUNT_W'(H_ACTIVE);
  localparam logic [VCOUNT_W-1:0] V_ACT       = VCOUNT_W'(V_ACTIVE);
  localparam logic [HCOUNT_W-1:0] HSYNC_START = HCOUNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCOUNT_W-1:0] HSYNC_END   = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCOUNT_W-1:0] VSYNC_START = VCOUNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCOUNT_W-1:0] VSYNC_END   = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FRAME_W-1:0]  FRAME_LAST  = FRAME_W'(FRAMES_PER_SEC - 1);

  logic [HCOUNT_W-1:0] hcount_q, hcount_d;
  logic [VCOUNT_W-1:0] vcount_q, vcount_d;
  logic                new_frame_q, new_frame_d;
  logic [FRAME_W-1:0]  frame_count_q, frame_count_d;
  logic [RGB_W-1:0]    pixel_q, pixel_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                active_q, active_d;

  sync_bundle_t bundle_raw;
  sync_bundle_t bundle_dly;
  logic         unused_bits;

  // The tick is decoded from the next-state counters so it lands on the
  // same cycle the counters show H_ACTIVE/V_ACTIVE.
  always_comb begin
    hcount_d = hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
    end
    new_frame_d   = (hcount_d == H_ACT) && (vcount_d == V_ACT);
    frame_count_d = frame_count_q;
    if (new_frame_d) begin
      frame_count_d = (frame_count_q == FRAME_LAST) ? '0 : frame_count_q + 1'b1;
    end
  end

  always_comb begin
    bundle_raw        = '0;
    bundle_raw.hsync  = (hcount_q >= HSYNC_START) && (hcount_q < HSYNC_END);
    bundle_raw.vsync  = (vcount_q >= VSYNC_START) && (vcount_q < VSYNC_END);
    bundle_raw.active = (hcount_q < H_ACT) && (vcount_q < V_ACT);
`ifdef VIDEO_TEST_PATTERN_EN
    bundle_raw.hcol   = hcount_q[10:7];
`endif
  end

  pipe_delay #(
    .WIDTH ($bits(sync_bundle_t)),
    .DEPTH (PIXEL_LATENCY)
  ) u_sync_dly (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (bundle_raw),
    .data_out (bundle_dly)
  );

  always_comb begin
    hsync_d  = bundle_dly.hsync;
    vsync_d  = bundle_dly.vsync;
    active_d = bundle_dly.active;
    pixel_d  = '0;
    if (bundle_dly.active) begin
`ifdef VIDEO_TEST_PATTERN_EN
      pixel_d = test_pattern_in ? bar_colour(bundle_dly.hcol[2:0]) : pixel_in;
`else
      pixel_d = pixel_in;
`endif
    end
  end

`ifdef VIDEO_TEST_PATTERN_EN
  assign unused_bits = bundle_dly.hcol[3];
`else
  assign unused_bits = test_pattern_in ^ (^bundle_dly.hcol);
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      new_frame_q   <= 1'b0;
      frame_count_q <= '0;
      pixel_q       <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      new_frame_q   <= new_frame_d;
      frame_count_q <= frame_count_d;
      pixel_q       <= pixel_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
    end
  end

  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign new_frame_out   = new_frame_q;
  assign frame_count_out = frame_count_q;
  assign pixel_out       = pixel_q;
  assign hsync_out       = hsync_q;
  assign vsync_out       = vsync_q;
  assign active_draw_out = active_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_video_timing_gen : directed bench on a shrunken raster (150x6) so that
//                       61 frames fit; expectations come from cycle arithmetic.
// Revision            : 1.0
// ============================================================================
module tb_video_timing_gen;

  localparam int HA = 136, HFP = 4, HS = 4, HBP = 6;
  localparam int VA = 3,   VFP = 1, VS = 1, VBP = 1;
  localparam int LAT   = 4;
  localparam int HT    = HA + HFP + HS + HBP;   // 150
  localparam int VT    = VA + VFP + VS + VBP;   // 6
  localparam int FRAME = HT * VT;               // 900
  localparam int FIRST = VA * HT + HA;          // 586
`ifdef VIDEO_TEST_PATTERN_EN
  localparam bit TP_BUILT = 1'b1;
`else
  localparam bit TP_BUILT = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        test_pattern_in = 1'b0;
  logic [11:0] pixel_in = '0;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        new_frame_out;
  logic [5:0]  frame_count_out;
  logic [11:0] pixel_out;
  logic        hsync_out, vsync_out, active_draw_out;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .PIXEL_LATENCY (LAT)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .new_frame_out   (new_frame_out),
    .frame_count_out (frame_count_out),
    .pixel_in        (pixel_in),
    .test_pattern_in (test_pattern_in),
    .pixel_out       (pixel_out),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .active_draw_out (active_draw_out)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int eh(input int c);
    return c % HT;
  endfunction

  function automatic int ev(input int c);
    return (c / HT) % VT;
  endfunction

  function automatic int exp_fc(input int c);
    return (c >= FIRST) ? (((c - FIRST) / FRAME + 1) % 60) : 0;
  endfunction

  function automatic logic [11:0] exp_bar(input int h);
    case ((h / 128) % 8)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Renderer model: pixel for column h arrives LAT cycles after hcount_out=h.
  always @(posedge clk_in) begin
    #1;
    if (rst_in) cyc = 0;
    else        cyc = cyc + 1;
    pixel_in = (cyc >= LAT) ? {4'(eh(cyc - LAT)), 8'h00} : 12'h000;
  end

  task automatic check_cycle(input int c);
    int          k;
    logic        ehs, evs, ea;
    logic [11:0] ep;
    k   = c - LAT - 1;
    ehs = 1'b0; evs = 1'b0; ea = 1'b0; ep = 12'h000;
    check_val("hcount", 32'(hcount_out), 32'(eh(c)));
    check_val("vcount", 32'(vcount_out), 32'(ev(c)));
    check_val("new_frame", 32'(new_frame_out), 32'(eh(c) == HA && ev(c) == VA));
    check_val("frame_count", 32'(frame_count_out), 32'(exp_fc(c)));
    if (k >= 0) begin
      ehs = (eh(k) >= HA + HFP) && (eh(k) < HA + HFP + HS);
      evs = (ev(k) >= VA + VFP) && (ev(k) < VA + VFP + VS);
      ea  = (eh(k) < HA) && (ev(k) < VA);
      if (ea) ep = (TP_BUILT && test_pattern_in) ? exp_bar(eh(k)) : {4'(eh(k)), 8'h00};
    end
    check_val("hsync", 32'(hsync_out), 32'(ehs));
    check_val("vsync", 32'(vsync_out), 32'(evs));
    check_val("active", 32'(active_draw_out), 32'(ea));
    check_val("pixel", 32'(pixel_out), 32'(ep));
    if (k >= 0 && ev(k) < VA && eh(k) == HA - 1) check_val("col_last", 32'(active_draw_out), 32'd1);
    if (k >= 0 && ev(k) < VA && eh(k) == HA)     check_val("col_blank", 32'(pixel_out), 32'h000);
    if (test_pattern_in && k >= 0 && ev(k) == 0 && eh(k) == 0)
      check_val("col0", 32'(pixel_out), TP_BUILT ? 32'hFFF : 32'h000);
    if (test_pattern_in && k >= 0 && ev(k) == 0 && eh(k) == 129)
      check_val("col129", 32'(pixel_out), TP_BUILT ? 32'hFF0 : 32'h100);
  endtask

  initial begin
    int hs_cnt, vs_cnt, act_cnt, nf_cnt, nf_total, fc_peak;
    hs_cnt = 0; vs_cnt = 0; act_cnt = 0; nf_cnt = 0; nf_total = 0; fc_peak = 0;

    repeat (3) @(posedge clk_in);
    #2;
    check_val("rst_hcount", 32'(hcount_out), 32'd0);
    check_val("rst_vcount", 32'(vcount_out), 32'd0);
    check_val("rst_nf", 32'(new_frame_out), 32'd0);
    check_val("rst_fc", 32'(frame_count_out), 32'd0);
    check_val("rst_pixel", 32'(pixel_out), 32'd0);
    check_val("rst_sync", 32'({hsync_out, vsync_out, active_draw_out}), 32'd0);

    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check_cycle(0);

    // Three frames of full per-cycle checking; the third with the pattern select on.
    for (int c = 1; c <= 3 * FRAME; c++) begin
      @(posedge clk_in);
      #2;
      check_cycle(cyc);
      if (new_frame_out) nf_total++;
      if (cyc > FRAME && cyc <= 2 * FRAME) begin
        hs_cnt  += 32'(hsync_out);
        vs_cnt  += 32'(vsync_out);
        act_cnt += 32'(active_draw_out);
        nf_cnt  += 32'(new_frame_out);
      end
      if (cyc == 2 * FRAME) test_pattern_in = 1'b1;
    end
    test_pattern_in = 1'b0;
    check_val("hsync_cycles", 32'(hs_cnt), 32'(HS * VT));
    check_val("vsync_cycles", 32'(vs_cnt), 32'(VS * HT));
    check_val("active_cycles", 32'(act_cnt), 32'(HA * VA));
    check_val("ticks_per_frame", 32'(nf_cnt), 32'd1);

    for (int c = 3 * FRAME + 1; c <= 61 * FRAME; c++) begin
      logic exp_nf;
      @(posedge clk_in);
      #2;
      exp_nf = (eh(cyc) == HA) && (ev(cyc) == VA);
      if (new_frame_out || exp_nf) check_val("tick", 32'(new_frame_out), 32'(exp_nf));
      if (exp_nf) check_val("tick_fc", 32'(frame_count_out), 32'(exp_fc(cyc)));
      if (new_frame_out) nf_total++;
      if (int'(frame_count_out) > fc_peak) fc_peak = int'(frame_count_out);
    end
    check_val("tick_total", 32'(nf_total), 32'd61);
    check_val("fc_peak", 32'(fc_peak), 32'd59);
    check_val("fc_end", 32'(frame_count_out), 32'd1);

    // Abort mid-line at column 100.
    for (int i = 0; i < HT && eh(cyc) != 100; i++) begin
      @(posedge clk_in);
      #2;
    end
    check_val("pre_rst_hcount", 32'(hcount_out), 32'd100);
    #2;
    rst_in = 1'b1;
    #1;
    check_val("mid_rst_hcount", 32'(hcount_out), 32'd0);
    check_val("mid_rst_vcount", 32'(vcount_out), 32'd0);
    check_val("mid_rst_pixel", 32'(pixel_out), 32'd0);
    check_val("mid_rst_flags", 32'({new_frame_out, hsync_out, vsync_out, active_draw_out}), 32'd0);
    check_val("mid_rst_fc", 32'(frame_count_out), 32'd0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check_val("rel_hcount0", 32'(hcount_out), 32'd0);
    check_val("rel_vcount0", 32'(vcount_out), 32'd0);
    @(posedge clk_in);
    #2;
    check_val("rel_hcount1", 32'(hcount_out), 32'd1);
    check_val("rel_vcount1", 32'(vcount_out), 32'd0);
    check_val("rel_active1", 32'(active_draw_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
